// File: rtl/instr_fifo.sv
// Instruction buffer between instr_fetch and the decoder: 2**ADDR_W-deep FIFO
// with a registered pop/valid read port, occupancy count and sticky error flags.
module instr_fifo #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W + 1)'(AFULL_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [DATA_W-1:0] rd_data_reg, rd_data_next;
    logic              rd_valid_reg, rd_valid_next;
    logic              overflow_reg, overflow_next;
    logic              underflow_reg, underflow_next;

    logic              push_acc;
    logic              pop_acc;
    logic [DEPTH-1:0]  wr_sel;

    // Status flags come from the count register alone, so full never depends
    // combinationally on wr_en and the fetch-side handshake stays loop-free.
    assign full        = (count_reg == DEPTH_C);
    assign empty       = (count_reg == '0);
    assign almost_full = (count_reg >= AFULL_C);

    assign push_acc = wr_en & ~full  & ~flush;
    assign pop_acc  = rd_en & ~empty & ~flush;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_acc && (wr_ptr_reg == ADDR_W'(gi));
        end
    endgenerate

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        rd_data_next   = rd_data_reg;
        rd_valid_next  = 1'b0;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (flush) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            rd_valid_next = pop_acc;
            if (push_acc) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr_next  = rd_ptr_reg + 1'b1;
                rd_data_next = mem[rd_ptr_reg];
            end
            case ({push_acc, pop_acc})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
            if (wr_en && full) begin
                overflow_next = 1'b1;
            end
            if (rd_en && empty) begin
                underflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            rd_data_reg   <= rd_data_next;
            rd_valid_reg  <= rd_valid_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign count     = count_reg;
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_instr_fifo.sv
// Bench for instr_fifo: directed stimulus feeds a scoreboard queue of expected
// read words; a negedge monitor pops and compares whenever rd_valid is seen.
module tb_instr_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [63:0] wr_data = '0;
    logic        full;
    logic        almost_full;
    logic        rd_en = 1'b0;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_q[$];
    logic [63:0] m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;
    logic        m_rv  = 1'b0;

    instr_fifo #(.DATA_W(64), .ADDR_W(4), .AFULL_THRESH(14)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding pop.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got %h want none", rd_data);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic check_status(input string name);
        logic [10:0] act, exp;
        int n;
        n   = m_q.size();
        act = {count, full, empty, almost_full, rd_valid, overflow, underflow};
        exp = {5'(n), (n == 16), (n == 0), (n >= 14), m_rv, m_ovf, m_udf};
        chk(name, 64'(act), 64'(exp));
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge state.
    task automatic step(input logic we, input logic [63:0] wd, input logic re, input logic fl);
        logic m_full, m_empty;
        m_full  = (m_q.size() == 16);
        m_empty = (m_q.size() == 0);
        if (fl) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rv  = 1'b0;
        end else begin
            if (we && m_full)  m_ovf = 1'b1;
            if (re && m_empty) m_udf = 1'b1;
            m_rv = re && !m_empty;
            if (m_rv) exp_q.push_back(m_q.pop_front());
            if (we && !m_full) m_q.push_back(wd);
        end
        wr_en = we; wr_data = wd; rd_en = re; flush = fl;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        check_status("status");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_status("reset_state");

        // 1: async reset mid-operation, with a read pulse in flight
        for (int i = 0; i < 3; i++) step(1'b1, 64'h1000 + 64'(i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_empty", 64'(empty), 64'd1);
        chk("async_rst_full", 64'(full), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_rd_valid", 64'(rd_valid), 64'd0);
        exp_q.delete(); m_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_status("after_reset");

        // 2: fill with almost_full/full boundaries
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 64'h0400000000000100 + 64'(i), 1'b0, 1'b0);
            if (i == 12) chk("afull_at_13", 64'(almost_full), 64'd0);
            if (i == 13) chk("afull_at_14", 64'(almost_full), 64'd1);
            if (i == 14) chk("full_at_15", 64'(full), 64'd0);
            if (i == 15) chk("full_at_16", 64'(full), 64'd1);
        end

        // 3: overflow push is dropped
        step(1'b1, 64'hDEAD, 1'b0, 1'b0);
        chk("ovf_count", 64'(count), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);

        // full with push and pop together: pop wins, push rejected
        step(1'b1, 64'hBEEF, 1'b1, 1'b0);
        chk("full_both_count", 64'(count), 64'd15);

        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("drain_empty", 64'(empty), 64'd1);

        // 4: empty with push and pop together: no fall-through
        step(1'b1, 64'h8100000000000081, 1'b1, 1'b0);
        chk("udf_rd_valid", 64'(rd_valid), 64'd0);
        chk("udf_flag", 64'(underflow), 64'd1);
        chk("udf_count", 64'(count), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);

        // 5: preload 8, then 40 cycles of concurrent push/pop across wraps
        for (int i = 0; i < 8; i++) step(1'b1, 64'h5000 + 64'(i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 64'h6000 + 64'(i), 1'b1, 1'b0);
        chk("concurrent_count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

        // 6: flush beats a same-cycle push and clears sticky flags
        for (int i = 0; i < 5; i++) step(1'b1, 64'h7000 + 64'(i), 1'b0, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd5);
        step(1'b1, 64'hF1F1, 1'b0, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_ovf", 64'(overflow), 64'd0);
        chk("flush_udf", 64'(underflow), 64'd0);
        step(1'b1, 64'h00AB, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
